// File: rtl/stack_unit.sv
// Hardware call/return stack: LIFO of return addresses with a combinational top,
// full/empty decode, sticky overflow/underflow flags and a registered pop result.
module stack_unit #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clear_err,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] last_pop,
    output logic             pop_valid
);

    localparam logic [PTR_W:0] ONE       = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W:0]   top_ptr;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;
    logic             ovf_evt;
    logic             udf_evt;
    logic             pop_ok;

    assign top_ptr = count - ONE;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign top     = empty ? '0 : mem[top_ptr[PTR_W-1:0]];

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        wr_idx     = count[PTR_W-1:0];
        wr_en      = 1'b0;
        ovf_evt    = 1'b0;
        udf_evt    = 1'b0;
        pop_ok     = 1'b0;
        if (push && pop) begin
            if (empty) begin
                // Nothing to pop: behaves as a plain push into slot 0.
                wr_en      = 1'b1;
                wr_idx     = '0;
                count_next = ONE;
                udf_evt    = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_idx = top_ptr[PTR_W-1:0];
                pop_ok = 1'b1;
            end
        end else if (push) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en      = 1'b1;
                count_next = count + ONE;
            end
        end else if (pop) begin
            if (empty) begin
                udf_evt = 1'b1;
            end else begin
                count_next = count - ONE;
                pop_ok     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            pop_valid <= 1'b0;
            last_pop  <= '0;
        end else begin
            count     <= count_next;
            overflow  <= (overflow && !clear_err) || ovf_evt;
            underflow <= (underflow && !clear_err) || udf_evt;
            pop_valid <= pop_ok;
            if (pop_ok) begin
                last_pop <= top;
            end
        end
    end

    // NOTE: the storage array has no reset; count alone defines which entries
    // are valid, so clearing the array would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit: one task per scenario,
// each comparing DUT outputs against hand-computed values.
module tb_stack_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic        pop;
    logic [11:0] push_data;
    logic        clear_err;
    logic [11:0] top;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;
    logic [11:0] last_pop;
    logic        pop_valid;

    int checks   = 0;
    int failures = 0;

    stack_unit #(.WIDTH(12), .DEPTH(8), .PTR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clear_err (clear_err),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .last_pop  (last_pop),
        .pop_valid (pop_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ps, input logic pp, input logic [11:0] d, input logic ce);
        push      = ps;
        pop       = pp;
        push_data = d;
        clear_err = ce;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 12'h05A, 1'b0);
        tick();
        tick();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (top !== 12'h000) begin failures++; $display("FAIL reset_top got=%h exp=000", top); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid); end
        reset = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
    endtask

    task automatic test_lifo();
        logic [11:0] exp_vals [3];
        exp_vals[0] = 12'h033;
        exp_vals[1] = 12'h022;
        exp_vals[2] = 12'h011;
        apply_reset();
        drive(1'b1, 1'b0, 12'h011, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h022, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h033, 1'b0); tick();
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL lifo_count3 got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 12'h000, 1'b0);
            checks++; if (top !== exp_vals[i]) begin failures++; $display("FAIL lifo_top[%0d] got=%h exp=%h", i, top, exp_vals[i]); end
            tick();
            checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL lifo_pop_valid[%0d] got=%b exp=1", i, pop_valid); end
            checks++; if (last_pop !== exp_vals[i]) begin failures++; $display("FAIL lifo_last_pop[%0d] got=%h exp=%h", i, last_pop, exp_vals[i]); end
        end
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL lifo_pop_valid_drop got=%b exp=0", pop_valid); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL lifo_count_end got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL lifo_empty_end got=%b exp=1", empty); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL lifo_no_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 12'h100 + 12'(i), 1'b0);
            tick();
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
        drive(1'b1, 1'b0, 12'h1FF, 1'b0);
        tick();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (top !== 12'h107) begin failures++; $display("FAIL ovf_top got=%h exp=107", top); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 12'h000, 1'b0);
            checks++; if (top !== 12'h107 - 12'(i)) begin failures++; $display("FAIL drain_top[%0d] got=%h exp=%h", i, top, 12'h107 - 12'(i)); end
            tick();
        end
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (last_pop !== 12'h100) begin failures++; $display("FAIL drain_last_pop got=%h exp=100", last_pop); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_underflow_clear();
        apply_reset();
        drive(1'b0, 1'b1, 12'h000, 1'b0);
        tick();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_flag got=%b exp=1", underflow); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL udf_count got=%0d exp=0", count); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL udf_pop_valid got=%b exp=0", pop_valid); end
        checks++; if (last_pop !== 12'h000) begin failures++; $display("FAIL udf_last_pop got=%h exp=000", last_pop); end
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_sticky got=%b exp=1", underflow); end
        drive(1'b0, 1'b0, 12'h000, 1'b1);
        tick();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL clear_udf got=%b exp=0", underflow); end
        drive(1'b0, 1'b1, 12'h000, 1'b1);
        tick();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL clear_vs_err got=%b exp=1", underflow); end
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive(1'b1, 1'b0, 12'h0A1, 1'b0); tick();
        drive(1'b1, 1'b0, 12'h0A2, 1'b0); tick();
        drive(1'b1, 1'b1, 12'h0B3, 1'b0);
        tick();
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL swap_count got=%0d exp=2", count); end
        checks++; if (top !== 12'h0B3) begin failures++; $display("FAIL swap_top got=%h exp=0b3", top); end
        checks++; if (last_pop !== 12'h0A2) begin failures++; $display("FAIL swap_last_pop got=%h exp=0a2", last_pop); end
        checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL swap_pop_valid got=%b exp=1", pop_valid); end
        drive(1'b0, 1'b1, 12'h000, 1'b0);
        tick();
        checks++; if (top !== 12'h0A1) begin failures++; $display("FAIL swap_below got=%h exp=0a1", top); end

        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 12'h200 + 12'(i), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 12'h2FF, 1'b0);
        tick();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL swap_full_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL swap_full_overflow got=%b exp=0", overflow); end
        checks++; if (top !== 12'h2FF) begin failures++; $display("FAIL swap_full_top got=%h exp=2ff", top); end
        checks++; if (last_pop !== 12'h207) begin failures++; $display("FAIL swap_full_last_pop got=%h exp=207", last_pop); end

        apply_reset();
        drive(1'b1, 1'b1, 12'h0C4, 1'b0);
        tick();
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL swap_empty_count got=%0d exp=1", count); end
        checks++; if (top !== 12'h0C4) begin failures++; $display("FAIL swap_empty_top got=%h exp=0c4", top); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL swap_empty_underflow got=%b exp=1", underflow); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL swap_empty_pop_valid got=%b exp=0", pop_valid); end
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b0, 1'b1, 12'h000, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 12'h060 + 12'(i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 12'h000, 1'b0); tick();
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL mid_pre_count got=%0d exp=4", count); end
        reset = 1'b0;
        drive(1'b1, 1'b0, 12'h0EE, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
        checks++; if (top !== 12'h000) begin failures++; $display("FAIL mid_top got=%h exp=000", top); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL mid_underflow got=%b exp=0", underflow); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL mid_pop_valid got=%b exp=0", pop_valid); end
        checks++; if (last_pop !== 12'h000) begin failures++; $display("FAIL mid_last_pop got=%h exp=000", last_pop); end
        drive(1'b1, 1'b0, 12'h055, 1'b0);
        tick();
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL post_count got=%0d exp=1", count); end
        checks++; if (top !== 12'h055) begin failures++; $display("FAIL post_top got=%h exp=055", top); end
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 1'b0);
        #1;
        test_reset();
        test_lifo();
        test_fill_overflow();
        test_underflow_clear();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
